march_bist_ctrl: RTL and testbench
==================================

Name: march_bist_ctrl

Overview:
- March C- BIST engine that acts as the initiator for the accumulator RAM.
- Drives the RAM's synchronous write port and asynchronous read port, and checks every read value against the expected pattern in the same cycle.
- Reports pass/fail, the first failing address, expected and read data, and a saturating error count.
- Sits between the top-level BIST sequencer (start/done) and one RAM instance.

Parameters:
- DATA_WIDTH, 32, RAM word width.
- ARRAY_SIZE, 16, number of RAM words (N).
- ADDR_WIDTH, $clog2(ARRAY_SIZE), RAM address width.
- ERR_CNT_WIDTH, 8, width of the error counter.
- STOP_ON_FAIL, 0, when 1 the run ends on the first mismatch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid when done=1; equals 1 when err_cnt==0.
- err_cnt  out  ERR_CNT_WIDTH  number of mismatches, saturating at all-ones.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_expected  out  DATA_WIDTH  expected word at the first mismatch.
- fail_data  out  DATA_WIDTH  read word at the first mismatch.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_dout  in  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE.
  - busy, done, pass, err_cnt, fail_* and ram_wr_en are 0; ram_din, ram_wr_addr and ram_rd_addr are 0.
  - A reset during a run aborts it; RAM contents are then undefined.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. This clears err_cnt and fail_*, and loads element=0, op=0, addr=0.
  - DONE -> RUN on start=1, with the same clearing.
  - start is ignored in RUN.
- March C- sequence, with 0 = all-zeros word and 1 = all-ones word:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
  - "up" walks addr 0..N-1; "down" walks N-1..0. E3 and E4 load addr=N-1 on entry.
- Timing:
  - Each op takes exactly 1 cycle.
  - Within one element, all ops for an address complete before addr advances.
  - Total run length is 10N cycles (160 for N=16): 5N write cycles and 5N read cycles.
- RAM outputs are decoded from registered state only (no combinational path from start):
  - On a write op: ram_wr_en=1, ram_wr_addr=addr, ram_din=pattern.
  - Otherwise ram_wr_en=0 and ram_din=0.
  - ram_rd_addr=addr at all times in RUN.
- Read check:
  - On a read op, compare ram_dout to the expected word in the same cycle.
  - On a mismatch: increment err_cnt, saturating.
  - If this is the first mismatch, capture addr, expected and ram_dout into fail_*.
- End of run:
  - After the last op of E5, go to DONE on the next edge. done=1 and pass=(err_cnt==0) from that cycle.
  - If STOP_ON_FAIL=1, the first mismatch moves the state to DONE on the next edge, with err_cnt=1 and pass=0. Remaining ops are skipped.
- Boundary cases:
  - An address wrap ends the element; it never aliases.
  - ARRAY_SIZE need not be a power of 2. The terminal address is N-1 for up elements and 0 for down elements.
  - Saturation: err_cnt holds at 2^ERR_CNT_WIDTH-1.
  - A start held high continuously relaunches a run on the cycle after DONE is entered. done is high for one cycle in that case.

Test Plan:
- Fault-free RAM model, N=16, start pulsed at cycle 0:
  - busy is high for cycles 1..160; done=1 and pass=1 from cycle 161; err_cnt=0.
  - Exactly 80 cycles have ram_wr_en=1.
- Address order:
  - During E3 and E4, ram_rd_addr sequences 15,15,14,14,...,0,0.
  - During E0 and E5, it sequences 0..15.
- Stuck-at-0 on bit 3 at address 5, STOP_ON_FAIL=0:
  - pass=0, err_cnt=2 (E2 and E4 reads).
  - fail_addr=5, fail_expected=0xFFFFFFFF, fail_data=0xFFFFFFF7.
- Same fault with STOP_ON_FAIL=1:
  - The mismatch occurs at run cycle index 58 (0-based).
  - done=1 on the next cycle; err_cnt=1; no further RAM writes after the mismatch.
- rst_n pulsed low at run cycle 50:
  - All outputs are 0 immediately (async), and ram_wr_en=0.
  - A new start produces a full clean 160-cycle run with pass=1.
- start pulsed at run cycle 20 is ignored: the run length is unchanged.
- Error saturation: every read forced wrong with ERR_CNT_WIDTH=4 gives err_cnt=15.
- Restart: start in DONE clears err_cnt and fail_* on the transition edge.

Source files
------------

// File: rtl/march_bist_ctrl.sv
// March C- BIST engine driving one accumulator RAM: sync write port, async read port,
// every read compared to the expected pattern in the same cycle.
module march_bist_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ARRAY_SIZE    = 16,
  parameter int ADDR_WIDTH    = $clog2(ARRAY_SIZE),
  parameter int ERR_CNT_WIDTH = 8,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [DATA_WIDTH-1:0]    fail_expected,
  output logic [DATA_WIDTH-1:0]    fail_data,
  output logic                     ram_wr_en,
  output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  // Start/done protocol: start is a level sampled only in IDLE or DONE; done stays high
  // until the next accepted start or reset, so the sequencer may pulse or hold start.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ARRAY_SIZE - 1);

  state_t                   state_q, state_d;
  logic [2:0]               elem_q, elem_d;
  logic                     op_q, op_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic [ADDR_WIDTH-1:0]    fail_addr_q;
  logic [DATA_WIDTH-1:0]    fail_exp_q, fail_data_q;

  logic                  running, is_write, is_read, mismatch, down, last_op, elem_end, clear;
  logic [DATA_WIDTH-1:0] wr_pattern, rd_expect;
  logic [ADDR_WIDTH-1:0] term_addr;

  // Op decode: E0 is w-only, E5 is r-only, E1..E4 are (read, write) pairs on op 0/1.
  always_comb begin
    running    = (state_q == S_RUN);
    is_write   = running && ((elem_q == 3'd0) || ((elem_q <= 3'd4) && op_q));
    is_read    = running && !is_write;
    wr_pattern = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
    rd_expect  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
    mismatch   = is_read && (ram_dout != rd_expect);
    down       = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_op    = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
    term_addr  = down ? '0 : LAST_ADDR;
    elem_end   = last_op && (addr_q == term_addr);
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    op_d    = op_q;
    addr_d  = addr_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          op_d    = 1'b0;
          addr_d  = '0;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        if ((STOP_ON_FAIL != 0) && mismatch) begin
          state_d = S_DONE;
        end else if (!last_op) begin
          op_d = 1'b1;
        end else if (!elem_end) begin
          op_d   = 1'b0;
          addr_d = down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
        end else if (elem_q == 3'd5) begin
          state_d = S_DONE;
        end else begin
          // Entering E3/E4 walks downward from the top address.
          elem_d = elem_q + 3'd1;
          op_d   = 1'b0;
          addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      op_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
    end
  end

  // err_cnt==0 doubles as the "no mismatch seen yet" flag since it never wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_data_q <= '0;
    end else if (clear) begin
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_data_q <= '0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
      if (err_cnt_q == '0) begin
        fail_addr_q <= addr_q;
        fail_exp_q  <= rd_expect;
        fail_data_q <= ram_dout;
      end
    end
  end

  assign busy          = running;
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_cnt_q == '0);
  assign err_cnt       = err_cnt_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_exp_q;
  assign fail_data     = fail_data_q;
  assign ram_wr_en     = is_write;
  assign ram_wr_addr   = is_write ? addr_q : '0;
  assign ram_din       = is_write ? wr_pattern : '0;
  assign ram_rd_addr   = running ? addr_q : '0;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: three instances (default, stop-on-fail, 4-bit error count)
// each with its own RAM model and injectable read fault.
module tb_march_bist_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        start, busy, done, pass, ram_wr_en;
  logic [7:0]        err_cnt0, err_cnt1;
  logic [3:0]        err_cnt2;
  logic [2:0][3:0]   fail_addr, ram_wr_addr, ram_rd_addr;
  logic [2:0][31:0]  fail_expected, fail_data, ram_din, ram_dout;
  logic [31:0]       mem [3][16];
  int                fault_mode [3];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                rd_seq [160];

  always #5 clk = ~clk;

  march_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_cnt(err_cnt0), .fail_addr(fail_addr[0]),
    .fail_expected(fail_expected[0]), .fail_data(fail_data[0]), .ram_wr_en(ram_wr_en[0]),
    .ram_wr_addr(ram_wr_addr[0]), .ram_din(ram_din[0]), .ram_rd_addr(ram_rd_addr[0]),
    .ram_dout(ram_dout[0]));

  march_bist_ctrl #(.STOP_ON_FAIL(1)) dut_sof (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_cnt(err_cnt1), .fail_addr(fail_addr[1]),
    .fail_expected(fail_expected[1]), .fail_data(fail_data[1]), .ram_wr_en(ram_wr_en[1]),
    .ram_wr_addr(ram_wr_addr[1]), .ram_din(ram_din[1]), .ram_rd_addr(ram_rd_addr[1]),
    .ram_dout(ram_dout[1]));

  march_bist_ctrl #(.ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_cnt(err_cnt2), .fail_addr(fail_addr[2]),
    .fail_expected(fail_expected[2]), .fail_data(fail_data[2]), .ram_wr_en(ram_wr_en[2]),
    .ram_wr_addr(ram_wr_addr[2]), .ram_din(ram_din[2]), .ram_rd_addr(ram_rd_addr[2]),
    .ram_dout(ram_dout[2]));

  // RAM models: fault 1 = bit 3 of address 5 stuck at 0, fault 2 = every read inverted.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (ram_wr_en[k]) mem[k][ram_wr_addr[k]] <= ram_din[k];
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ram_dout[k] = mem[k][ram_rd_addr[k]];
      if (fault_mode[k] == 1 && ram_rd_addr[k] == 4'd5) ram_dout[k][3] = 1'b0;
      if (fault_mode[k] == 2) ram_dout[k] = ~ram_dout[k];
    end
  end

  function automatic int get_err(input int k);
    if (k == 0) return int'(err_cnt0);
    if (k == 1) return int'(err_cnt1);
    return int'(err_cnt2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One run on instance k; optionally re-pulses start at run cycle poke_at.
  task automatic run_vec(input int k, input int poke_at, output int len, output int wr);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    len = 0;
    wr  = 0;
    while (busy[k] && len < 2000) begin
      if (len < 160) rd_seq[len] = int'(ram_rd_addr[k]);
      wr = wr + (ram_wr_en[k] ? 1 : 0);
      start[k] = (len == poke_at);
      len++;
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    int          fault;
    int          poke_at;
    logic        exp_pass;
    int          exp_err;
    logic [3:0]  exp_addr;
    logic [31:0] exp_fexp;
    logic [31:0] exp_fdata;
    int          exp_len;
    int          exp_wr;
  } vec_t;

  vec_t vecs [5];

  task automatic check_vec(input int v, input int len, input int wr);
    int k;
    k = vecs[v].k;
    check($sformatf("v%0d run_len", v), 32'(len), 32'(vecs[v].exp_len));
    check($sformatf("v%0d wr_cycles", v), 32'(wr), 32'(vecs[v].exp_wr));
    check($sformatf("v%0d done", v), 32'(done[k]), 32'd1);
    check($sformatf("v%0d pass", v), 32'(pass[k]), 32'(vecs[v].exp_pass));
    check($sformatf("v%0d err_cnt", v), 32'(get_err(k)), 32'(vecs[v].exp_err));
    check($sformatf("v%0d fail_addr", v), 32'(fail_addr[k]), 32'(vecs[v].exp_addr));
    check($sformatf("v%0d fail_expected", v), fail_expected[k], vecs[v].exp_fexp);
    check($sformatf("v%0d fail_data", v), fail_data[k], vecs[v].exp_fdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, wr, n;
    // v0 clean; v1 stuck bit + ignored mid-run start; v2 restart from a failed DONE;
    // v3 stop-on-fail at run cycle 58; v4 all reads wrong, 4-bit counter saturates.
    vecs[0] = '{0, 0, -1, 1'b1, 0,  4'd0, 32'h0,        32'h0,        160, 80};
    vecs[1] = '{0, 1, 20, 1'b0, 2,  4'd5, 32'hFFFFFFFF, 32'hFFFFFFF7, 160, 80};
    vecs[2] = '{0, 0, -1, 1'b1, 0,  4'd0, 32'h0,        32'h0,        160, 80};
    vecs[3] = '{1, 1, -1, 1'b0, 1,  4'd5, 32'hFFFFFFFF, 32'hFFFFFFF7, 59,  37};
    vecs[4] = '{2, 2, -1, 1'b0, 15, 4'd0, 32'h0,        32'hFFFFFFFF, 160, 80};

    rst_n = 1'b0;
    start = '0;
    for (int k = 0; k < 3; k++) fault_mode[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pass", 32'(pass), 32'd0);
    check("reset wr_en", 32'(ram_wr_en), 32'd0);
    check("reset err_cnt", 32'(get_err(0)), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      fault_mode[vecs[v].k] = vecs[v].fault;
      run_vec(vecs[v].k, vecs[v].poke_at, len, wr);
      check_vec(v, len, wr);
      if (v == 0) begin
        for (int i = 0; i < 16; i++) begin
          check($sformatf("E0 rd_addr[%0d]", i), 32'(rd_seq[i]), 32'(i));
          check($sformatf("E5 rd_addr[%0d]", i), 32'(rd_seq[144 + i]), 32'(i));
          check($sformatf("E3 rd_addr[%0d]", i), 32'(rd_seq[80 + 2 * i]), 32'(15 - i));
          check($sformatf("E3 rd_addr[%0d]b", i), 32'(rd_seq[81 + 2 * i]), 32'(15 - i));
          check($sformatf("E4 rd_addr[%0d]", i), 32'(rd_seq[112 + 2 * i]), 32'(15 - i));
          check($sformatf("E4 rd_addr[%0d]b", i), 32'(rd_seq[113 + 2 * i]), 32'(15 - i));
        end
      end
    end

    // Asynchronous abort at run cycle 50, then a clean rerun.
    fault_mode[0] = 0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check("pre-abort busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort done", 32'(done[0]), 32'd0);
    check("abort pass", 32'(pass[0]), 32'd0);
    check("abort wr_en", 32'(ram_wr_en[0]), 32'd0);
    check("abort wr_addr", 32'(ram_wr_addr[0]), 32'd0);
    check("abort din", ram_din[0], 32'd0);
    check("abort rd_addr", 32'(ram_rd_addr[0]), 32'd0);
    check("abort err_cnt", 32'(get_err(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(0, -1, len, wr);
    check_vec(0, len, wr);

    // Held start: done lasts one cycle before the relaunch.
    start[0] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done[0] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("held first run_len", 32'(n), 32'd160);
    check("held done", 32'(done[0]), 32'd1);
    @(posedge clk); #1;
    check("held relaunch busy", 32'(busy[0]), 32'd1);
    check("held relaunch done", 32'(done[0]), 32'd0);
    start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("held second run_len", 32'(n), 32'd160);
    check("held second pass", 32'(pass[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
